// File: rtl/keypad_scanner_pkg.sv
// Shared types and key-code table for the 4x4 matrix keypad scanner.
// Codes follow the game kernel's key numbering: digits as values, A-D then * and #.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        SCAN         = 2'd0,
        DEBOUNCE     = 2'd1,
        READY        = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
        logic [3:0] code;
        case ({row_idx, col_idx})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'hA:    code = 4'd9;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // Lowest-numbered active-low column wins when several keys share a row.
    function automatic logic [1:0] lowest_low(input logic [3:0] cols);
        logic [1:0] idx;
        casez (cols)
            4'b???0: idx = 2'd0;
            4'b??01: idx = 2'd1;
            4'b?011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key hand-off to the game kernel: 4-bit code qualified by an active-low ready strobe.
interface keypad_scanner_if;
    logic [3:0] key;
    logic       is_ready;

    modport master (output key, output is_ready);
    modport slave  (input  key, input  is_ready);
endinterface

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column inputs.
// Resets to all ones so an idle (pulled-up) keypad is seen during reset.
module keypad_scanner_col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates row drive, debounces one press, holds a ready strobe
// long enough for the kernel's slow tick, then waits for a clean full release.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE_CYC = 2_000_000,
    parameter int READY_HOLD   = 5_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       col,
    output logic [3:0]       row,
    keypad_scanner_if.master kif
);

    localparam int CNT_MAX = (DEBOUNCE_CYC > READY_HOLD) ? DEBOUNCE_CYC : READY_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int SLOT_W  = $clog2(SCAN_DIV) + 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(READY_HOLD - 1);

    state_t            r_state;
    state_t            w_next;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_row;
    logic [1:0]        r_row_idx;
    logic [1:0]        r_col_idx;
    logic [3:0]        r_key;
    logic              r_is_ready;

    logic [3:0]        w_col_s;
    logic              w_slot_end;
    logic              w_any_low;
    logic              w_key_low;
    logic              w_deb_done;
    logic              w_hold_done;

    keypad_scanner_col_sync #(.WIDTH(4)) u_col_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_async (col),
        .o_sync  (w_col_s)
    );

    assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
    assign w_any_low   = (w_col_s != 4'hF);
    assign w_key_low   = !w_col_s[r_col_idx];
    assign w_deb_done  = (r_cnt == DEB_LAST);
    assign w_hold_done = (r_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SCAN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SCAN: begin
                if (w_slot_end && w_any_low) w_next = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!w_key_low)      w_next = SCAN;
                else if (w_deb_done) w_next = READY;
            end
            READY: begin
                if (w_hold_done) w_next = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!w_any_low && w_deb_done) w_next = SCAN;
            end
            default: w_next = SCAN;
        endcase
    end

    // One counter serves debounce, strobe hold and release timing; states never overlap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cnt <= '0;
            r_cnt      <= '0;
            r_row      <= 4'b1110;
            r_row_idx  <= 2'd0;
            r_col_idx  <= 2'd0;
            r_key      <= 4'd0;
            r_is_ready <= 1'b1;
        end else begin
            case (r_state)
                SCAN: begin
                    r_cnt <= '0;
                    if (w_slot_end) begin
                        r_slot_cnt <= '0;
                        if (w_any_low) begin
                            r_col_idx <= lowest_low(w_col_s);
                        end else begin
                            r_row     <= {r_row[2:0], r_row[3]};
                            r_row_idx <= r_row_idx + 2'd1;
                        end
                    end else begin
                        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!w_key_low || w_deb_done) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_key_low && w_deb_done) begin
                        r_key      <= keymap(r_row_idx, r_col_idx);
                        r_is_ready <= 1'b0;
                    end
                end
                READY: begin
                    if (w_hold_done) begin
                        r_cnt      <= '0;
                        r_is_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (w_any_low) begin
                        r_cnt <= '0;
                    end else if (w_deb_done) begin
                        r_cnt      <= '0;
                        r_slot_cnt <= '0;
                        r_row      <= 4'b1110;
                        r_row_idx  <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    // Outputs come straight from flops so the keypad rows and the kernel never see decode glitches.
    always_comb begin
        row          = r_row;
        kif.key      = r_key;
        kif.is_ready = r_is_ready;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives columns from the row drive,
// stimulus queues expected key codes, and a negedge monitor checks every strobe.
module tb_keypad_scanner;

    localparam int SCAN_DIV     = 8;
    localparam int DEBOUNCE_CYC = 20;
    localparam int READY_HOLD   = 50;

    typedef struct {
        logic [3:0] code;
        bit         chk_len;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] r_press;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    bit         m_in_strobe = 1'b0;
    bit         m_have = 1'b0;
    bit         m_stable = 1'b1;
    int         m_len = 0;
    exp_t       m_cur;
    logic [3:0] m_key;

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .READY_HOLD   (READY_HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .col     (col),
        .row     (row),
        .kif     (kif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pressed key at [r][c] pulls column c low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (r_press[r*4+c]) col[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_key(input logic [3:0] code, input bit chk_len);
        exp_t e;
        e.code    = code;
        e.chk_len = chk_len;
        q.push_back(e);
    endtask

    task automatic wait_ready(input logic lvl, input int max_cyc, input string name);
        int n = 0;
        while (kif.is_ready !== lvl && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (kif.is_ready !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s timeout is_ready=%0d expected=%0d", name, kif.is_ready, lvl);
        end
    endtask

    task automatic hold_key(input int idx, input int cyc);
        r_press[idx] = 1'b1;
        repeat (cyc) @(posedge clk);
        r_press[idx] = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (kif.is_ready === 1'b0) begin
                if (!m_in_strobe) begin
                    m_in_strobe = 1'b1;
                    m_len       = 0;
                    m_stable    = 1'b1;
                    m_key       = kif.key;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        m_have = 1'b0;
                        $display("FAIL unexpected_strobe key=%0d expected no strobe at %0t", kif.key, $time);
                    end else begin
                        m_cur  = q.pop_front();
                        m_have = 1'b1;
                        chk("strobe_key", int'(kif.key), int'(m_cur.code));
                    end
                end else if (kif.key !== m_key) begin
                    m_stable = 1'b0;
                end
                m_len++;
            end else if (m_in_strobe) begin
                m_in_strobe = 1'b0;
                if (m_have) begin
                    chk("key_stable", int'(m_stable), 1);
                    if (m_cur.chk_len) chk("hold_len", m_len, READY_HOLD);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        r_press = '0;

        // Reset values, then a reset in the middle of scanning
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row", int'(row), 14);
        chk("rst_ready", int'(kif.is_ready), 1);
        chk("rst_key", int'(kif.key), 0);
        @(negedge clk) reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("midscan_rst_row", int'(row), 14);
        chk("midscan_rst_ready", int'(kif.is_ready), 1);
        chk("midscan_rst_key", int'(kif.key), 0);
        @(negedge clk) reset_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1;
            chk("rotate", int'(row), (~(1 << ((k / 8) % 4))) & 15);
        end

        // '5' held long: one strobe only; then '9'
        expect_key(4'd5, 1'b1);
        hold_key(5, 200);
        repeat (40) @(posedge clk);
        #1;
        chk("key_kept", int'(kif.key), 5);
        expect_key(4'd9, 1'b1);
        hold_key(10, 150);
        repeat (40) @(posedge clk);

        // '1' with a short bounce burst before the real press
        expect_key(4'd1, 1'b1);
        hold_key(0, 10);
        repeat (3) @(posedge clk);
        hold_key(0, 100);
        repeat (100) @(posedge clk);

        // '#' and 'D' together on row 3: lowest column wins
        expect_key(4'd15, 1'b1);
        r_press[15] = 1'b1;
        hold_key(14, 150);
        r_press[15] = 1'b0;
        repeat (40) @(posedge clk);

        // '0', released during the strobe, then a one-cycle glitch at release count 15
        expect_key(4'd0, 1'b1);
        r_press[13] = 1'b1;
        wait_ready(1'b0, 200, "strobe0_start");
        repeat (5) @(posedge clk);
        r_press[13] = 1'b0;
        wait_ready(1'b1, 100, "strobe0_end");
        repeat (13) @(posedge clk);
        @(negedge clk) r_press[13] = 1'b1;
        @(posedge clk);
        @(negedge clk) r_press[13] = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("glitch_still_frozen", int'(row), 7);
        @(posedge clk);
        #1;
        chk("glitch_scan_row0", int'(row), 14);
        repeat (20) @(posedge clk);

        // Reset while the strobe is active
        expect_key(4'd5, 1'b0);
        r_press[5] = 1'b1;
        wait_ready(1'b0, 200, "strobe5_start");
        repeat (10) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("ready_rst_ready", int'(kif.is_ready), 1);
        chk("ready_rst_key", int'(kif.key), 0);
        chk("ready_rst_row", int'(row), 14);
        r_press[5] = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_scan", int'(row), 13);
        repeat (100) @(posedge clk);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
